// File: rtl/spi_slave_resp_if.sv
// Bus bundle between the SPI responder, the SPI pins and the local byte-stream consumer/producer.
interface spi_slave_resp_if;
    logic       spi_SCLK;
    logic       spi_MOSI;
    logic       spi_SS_n;
    logic       spi_MISO;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;

    modport slave (
        input  spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready, overrun_clr,
        output spi_MISO, tx_ready, rx_data, rx_valid, overrun, busy
    );

    modport master (
        output spi_SCLK, spi_MOSI, spi_SS_n, tx_data, tx_valid, rx_ready, overrun_clr,
        input  spi_MISO, tx_ready, rx_data, rx_valid, overrun, busy
    );
endinterface

// File: rtl/spi_slave_resp.sv
// Oversampling SPI responder: one byte in / one byte out per slot, single-entry tx buffer, valid/ready rx.
// Optional: define SPI_SLAVE_RESP_MISO_TRISTATE_EN to release MISO (high-Z) while not selected.
module spi_slave_resp #(
    parameter bit         CPOL       = 1'b0,
    parameter bit         CPHA       = 1'b0,
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    spi_slave_resp_if.slave    bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q, state_n;
    logic                sclk_s1, sclk_s2, sclk_d;
    logic                mosi_s1, mosi_s2;
    logic                ss_s1, ss_s2, ss_d;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [BYTE_W-2:0]   rx_sh_q, rx_sh_n;
    logic [BYTE_W-1:0]   tx_sh_q, tx_sh_n;
    logic [BYTE_W-1:0]   tx_buf_q, tx_buf_n;
    logic                tx_ready_q, tx_ready_n;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_n;
    logic                rx_valid_q, rx_valid_n;
    logic                overrun_q, overrun_n;
    logic                busy_q, busy_n;
    logic                miso_q, miso_n;

    logic                ss_fall, ss_rise, lead_edge, trail_edge, sample_edge, shift_edge;
    logic [BYTE_W-1:0]   next_tx;
    logic                consume, rx_done, overrun_set;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_d  <= CPOL;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
        end else begin
            sclk_s1 <= bus.spi_SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= bus.spi_MOSI;
            mosi_s2 <= mosi_s1;
            ss_s1   <= bus.spi_SS_n;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
        end
    end

    assign ss_fall     = ss_d & ~ss_s2;
    assign ss_rise     = ~ss_d & ss_s2;
    assign lead_edge   = (sclk_s2 != CPOL) && (sclk_d == CPOL);
    assign trail_edge  = (sclk_s2 == CPOL) && (sclk_d != CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;
    assign next_tx     = tx_ready_q ? DEFAULT_TX : tx_buf_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            rx_sh_q    <= rx_sh_n;
            tx_sh_q    <= tx_sh_n;
            tx_buf_q   <= tx_buf_n;
            tx_ready_q <= tx_ready_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            overrun_q  <= overrun_n;
            busy_q     <= busy_n;
            miso_q     <= miso_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        rx_sh_n     = rx_sh_q;
        tx_sh_n     = tx_sh_q;
        tx_buf_n    = tx_buf_q;
        tx_ready_n  = tx_ready_q;
        rx_data_n   = rx_data_q;
        rx_valid_n  = rx_valid_q;
        overrun_n   = overrun_q;
        busy_n      = busy_q;
        miso_n      = miso_q;
        consume     = 1'b0;
        rx_done     = 1'b0;
        overrun_set = 1'b0;

        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_n = 1'b0;
        end

        // SS_n edges take priority; SCLK edges are only acted on mid-frame.
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_n = ACTIVE;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    tx_sh_n = next_tx;
                    consume = 1'b1;
                    if (!CPHA) begin
                        miso_n = next_tx[BYTE_W-1];
                    end
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    miso_n  = 1'b1;
                    cnt_n   = '0;
                end else if (sample_edge) begin
                    rx_sh_n = {rx_sh_q[BYTE_W-3:0], mosi_s2};
                    cnt_n   = CNT_W'(cnt_q + CNT_W'(1));
                    if (cnt_q == CNT_W'(BYTE_W - 1)) begin
                        rx_done = 1'b1;
                        cnt_n   = '0;
                        tx_sh_n = next_tx;
                        consume = 1'b1;
                        if (!CPHA) begin
                            miso_n = next_tx[BYTE_W-1];
                        end
                    end
                end else if (shift_edge) begin
                    miso_n = tx_sh_q[~cnt_q];
                end
            end
            default: state_n = IDLE;
        endcase

        if (consume) begin
            tx_ready_n = 1'b1;
        end
        // A write lands after any same-cycle consume so it is never lost.
        if (bus.tx_valid && tx_ready_q) begin
            tx_buf_n   = bus.tx_data;
            tx_ready_n = 1'b0;
        end

        if (rx_done) begin
            rx_data_n   = {rx_sh_q, mosi_s2};
            rx_valid_n  = 1'b1;
            overrun_set = rx_valid_q && !bus.rx_ready;
        end

        if (bus.overrun_clr) begin
            overrun_n = 1'b0;
        end
        if (overrun_set) begin
            overrun_n = 1'b1;
        end
    end

`ifdef SPI_SLAVE_RESP_MISO_TRISTATE_EN
    assign bus.spi_MISO = busy_q ? miso_q : 1'bz;
`else
    assign bus.spi_MISO = miso_q;
`endif
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: mode 0 and mode 3 instances driven by a timed SPI master model.
module tb_spi_slave_resp;
    localparam int HALF = 40;

    logic clk_clk = 1'b0;
    logic reset_reset;
    int   chk  = 0;
    int   pass = 0;

    always #5 clk_clk = ~clk_clk;

    spi_slave_resp_if if0();
    spi_slave_resp_if if3();

    spi_slave_resp #(.CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) dut0 (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .bus(if0.slave));
    spi_slave_resp #(.CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'hFF)) dut3 (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .bus(if3.slave));

    // Mode 0 master: MOSI set after the falling edge, MISO captured on the rising edge.
    task automatic m0_bits(input logic [7:0] b, input int n, input bit pulse, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if0.spi_MOSI = b[i];
            #HALF;
            if0.spi_SCLK = 1'b1;
            got[i] = if0.spi_MISO;
            if (pulse && i == 0) begin
                #14; if0.rx_ready = 1'b1;
                #10; if0.rx_ready = 1'b0;
                #16;
            end else begin
                #HALF;
            end
            if0.spi_SCLK = 1'b0;
        end
    endtask

    // Mode 3 master: MOSI set on the falling (leading) edge, MISO captured on the rising edge.
    task automatic m3_bits(input logic [7:0] b, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            if3.spi_SCLK = 1'b0;
            if3.spi_MOSI = b[i];
            #HALF;
            if3.spi_SCLK = 1'b1;
            got[i] = if3.spi_MISO;
            #HALF;
        end
    endtask

    task automatic pop0();
        if0.rx_ready = 1'b1; #10; if0.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        #10;
        chk++; if (if0.spi_MISO !== 1'b1) $display("FAIL rst_miso got=%b exp=1", if0.spi_MISO); else pass++;
        chk++; if (if0.tx_ready !== 1'b1) $display("FAIL rst_tx_ready got=%b exp=1", if0.tx_ready); else pass++;
        chk++; if (if0.rx_data !== 8'h00) $display("FAIL rst_rx_data got=%h exp=00", if0.rx_data); else pass++;
        chk++; if (if0.rx_valid !== 1'b0) $display("FAIL rst_rx_valid got=%b exp=0", if0.rx_valid); else pass++;
        chk++; if (if0.overrun !== 1'b0) $display("FAIL rst_overrun got=%b exp=0", if0.overrun); else pass++;
        chk++; if (if3.busy !== 1'b0) $display("FAIL rst_busy3 got=%b exp=0", if3.busy); else pass++;
        #10;
        reset_reset = 1'b0;
        #20;
    endtask

    task automatic test_mode0();
        logic [7:0] got;
        if0.tx_data = 8'hA5; if0.tx_valid = 1'b1; #10; if0.tx_valid = 1'b0;
        chk++; if (if0.tx_ready !== 1'b0) $display("FAIL m0_tx_full got=%b exp=0", if0.tx_ready); else pass++;
        if0.spi_SS_n = 1'b0; #(2*HALF);
        chk++; if (if0.busy !== 1'b1) $display("FAIL m0_busy got=%b exp=1", if0.busy); else pass++;
        m0_bits(8'h3C, 8, 1'b0, got);
        #HALF; if0.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (got !== 8'hA5) $display("FAIL m0_miso_byte got=%h exp=a5", got); else pass++;
        chk++; if (if0.rx_data !== 8'h3C) $display("FAIL m0_rx_data got=%h exp=3c", if0.rx_data); else pass++;
        chk++; if (if0.rx_valid !== 1'b1) $display("FAIL m0_rx_valid got=%b exp=1", if0.rx_valid); else pass++;
        chk++; if (if0.tx_ready !== 1'b1) $display("FAIL m0_tx_ready got=%b exp=1", if0.tx_ready); else pass++;
        chk++; if (if0.busy !== 1'b0) $display("FAIL m0_busy_end got=%b exp=0", if0.busy); else pass++;
        chk++; if (if0.spi_MISO !== 1'b1) $display("FAIL m0_miso_idle got=%b exp=1", if0.spi_MISO); else pass++;
        pop0();
        chk++; if (if0.rx_valid !== 1'b0) $display("FAIL m0_rx_pop got=%b exp=0", if0.rx_valid); else pass++;
    endtask

    task automatic test_default_tx();
        logic [7:0] got;
        if0.spi_SS_n = 1'b0; #(2*HALF);
        m0_bits(8'h00, 8, 1'b0, got);
        #HALF; if0.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (got !== 8'hFF) $display("FAIL dflt_miso_byte got=%h exp=ff", got); else pass++;
        chk++; if (if0.rx_data !== 8'h00) $display("FAIL dflt_rx_data got=%h exp=00", if0.rx_data); else pass++;
        chk++; if (if0.overrun !== 1'b0) $display("FAIL dflt_overrun got=%b exp=0", if0.overrun); else pass++;
        pop0();
    endtask

    task automatic test_back_to_back(input bit pulse);
        logic [7:0] g1, g2;
        if0.spi_SS_n = 1'b0; #(2*HALF);
        m0_bits(8'h11, 8, 1'b0, g1);
        m0_bits(8'h22, 8, pulse, g2);
        #HALF; if0.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (if0.rx_data !== 8'h22) $display("FAIL b2b_rx_data(p=%0d) got=%h exp=22", pulse, if0.rx_data); else pass++;
        chk++; if (if0.rx_valid !== 1'b1) $display("FAIL b2b_rx_valid(p=%0d) got=%b exp=1", pulse, if0.rx_valid); else pass++;
        if (pulse) begin
            chk++; if (if0.overrun !== 1'b0) $display("FAIL b2b_no_overrun got=%b exp=0", if0.overrun); else pass++;
        end else begin
            chk++; if (g2 !== 8'hFF) $display("FAIL b2b_miso_byte2 got=%h exp=ff", g2); else pass++;
            chk++; if (if0.overrun !== 1'b1) $display("FAIL b2b_overrun got=%b exp=1", if0.overrun); else pass++;
            if0.overrun_clr = 1'b1; #10; if0.overrun_clr = 1'b0;
            chk++; if (if0.overrun !== 1'b0) $display("FAIL b2b_overrun_clr got=%b exp=0", if0.overrun); else pass++;
        end
        pop0();
    endtask

    task automatic test_abort();
        logic [7:0] got;
        if0.spi_SS_n = 1'b0; #(2*HALF);
        m0_bits(8'hF0, 5, 1'b0, got);
        #HALF; if0.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (if0.rx_valid !== 1'b0) $display("FAIL abort_rx_valid got=%b exp=0", if0.rx_valid); else pass++;
        chk++; if (if0.busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", if0.busy); else pass++;
        if0.spi_SS_n = 1'b0; #(2*HALF);
        m0_bits(8'h81, 8, 1'b0, got);
        #HALF; if0.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (if0.rx_data !== 8'h81) $display("FAIL abort_next_rx got=%h exp=81", if0.rx_data); else pass++;
        chk++; if (if0.rx_valid !== 1'b1) $display("FAIL abort_next_valid got=%b exp=1", if0.rx_valid); else pass++;
        pop0();
    endtask

    task automatic test_mode3_and_reset();
        logic [7:0] got;
        if3.tx_data = 8'h5A; if3.tx_valid = 1'b1; #10; if3.tx_valid = 1'b0;
        if3.spi_SS_n = 1'b0; #(2*HALF);
        m3_bits(8'hC3, 8, got);
        if3.spi_SS_n = 1'b1; #(2*HALF);
        chk++; if (got !== 8'h5A) $display("FAIL m3_miso_byte got=%h exp=5a", got); else pass++;
        chk++; if (if3.rx_data !== 8'hC3) $display("FAIL m3_rx_data got=%h exp=c3", if3.rx_data); else pass++;
        chk++; if (if3.rx_valid !== 1'b1) $display("FAIL m3_rx_valid got=%b exp=1", if3.rx_valid); else pass++;
        if3.tx_data = 8'h00; if3.tx_valid = 1'b1; #10; if3.tx_valid = 1'b0;
        if3.spi_SS_n = 1'b0; #(2*HALF);
        m3_bits(8'hAA, 4, got);
        if3.spi_SCLK = 1'b0; #20;
        chk++; if (if3.spi_MISO !== 1'b0) $display("FAIL m3_mid_miso got=%b exp=0", if3.spi_MISO); else pass++;
        reset_reset = 1'b1; #1;
        chk++; if (if3.spi_MISO !== 1'b1) $display("FAIL mid_rst_miso got=%b exp=1", if3.spi_MISO); else pass++;
        chk++; if (if3.busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", if3.busy); else pass++;
        chk++; if (if3.tx_ready !== 1'b1) $display("FAIL mid_rst_tx_ready got=%b exp=1", if3.tx_ready); else pass++;
        chk++; if (if3.rx_data !== 8'h00) $display("FAIL mid_rst_rx_data got=%h exp=00", if3.rx_data); else pass++;
        chk++; if (if3.rx_valid !== 1'b0) $display("FAIL mid_rst_rx_valid got=%b exp=0", if3.rx_valid); else pass++;
        chk++; if (if3.overrun !== 1'b0) $display("FAIL mid_rst_overrun got=%b exp=0", if3.overrun); else pass++;
        #9;
        if3.spi_SCLK = 1'b1; if3.spi_SS_n = 1'b1;
        #20; reset_reset = 1'b0; #20;
    endtask

    initial begin
        reset_reset     = 1'b0;
        if0.spi_SCLK    = 1'b0; if0.spi_MOSI = 1'b0; if0.spi_SS_n = 1'b1;
        if0.tx_data     = 8'h00; if0.tx_valid = 1'b0; if0.rx_ready = 1'b0; if0.overrun_clr = 1'b0;
        if3.spi_SCLK    = 1'b1; if3.spi_MOSI = 1'b0; if3.spi_SS_n = 1'b1;
        if3.tx_data     = 8'h00; if3.tx_valid = 1'b0; if3.rx_ready = 1'b0; if3.overrun_clr = 1'b0;
        #3;
        test_reset();
        test_mode0();
        test_default_tx();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_abort();
        test_mode3_and_reset();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
